// File: rtl/rom_readback.sv
// rom_readback: Avalon-MM slave that streams PRG/CHR ROM bytes into a small word FIFO,
// packing little-endian and keeping a 16-bit running checksum for image verification.
module rom_readback #(
   parameter int ROM_LATENCY = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [1:0]  AVL_ADDR,
   input  logic        AVL_CS,
   input  logic        AVL_READ,
   input  logic        AVL_WRITE,
   input  logic [31:0] AVL_WRITEDATA,
   output logic [31:0] AVL_READDATA,
   output logic [15:0] ROM_ADDR,
   output logic        PRG_ROM_READ,
   output logic        CHR_ROM_READ,
   input  logic [7:0]  ROM_Q
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [2:0] WAIT_LAST = (ROM_LATENCY > 1) ? 3'(ROM_LATENCY - 2) : 3'd0;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_CAPTURE = 2'd3} state_t;

   function automatic logic [31:0] lane_insert(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [7:0] b);
      logic [31:0] w;
      w = word;
      case (lane)
         2'd0:    w[7:0]   = b;
         2'd1:    w[15:8]  = b;
         2'd2:    w[23:16] = b;
         default: w[31:24] = b;
      endcase
      return w;
   endfunction

   function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [7:0] b);
      return sum + {8'd0, b};
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   state_t            state_r, state_nx_s;
   logic [15:0]       addr_r, checksum_r;
   logic              sel_r, sel_nx_s, hold_r, done_r, underflow_r;
   logic [16:0]       count_r, remaining_r;
   logic [1:0]        lane_r;
   logic [31:0]       pack_r, readdata_r;
   logic [2:0]        wait_cnt_r;
   logic              prg_read_r, chr_read_r;
   logic [31:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
   logic [3:0]        level_r;

   logic wr_s, rd_s, ctrl_wr_s, count_wr_s, status_wr_s, data_rd_s;
   logic abort_s, start_s, busy_s, in_cap_s, fifo_full_s, fifo_empty_s;
   logic word_done_s, last_s, cap_push_s, pop_s, done_set_s;
   logic [31:0] cap_word_s, push_word_s, status_s;
   logic unused_s;

   assign wr_s        = AVL_CS & AVL_WRITE;
   assign rd_s        = AVL_CS & AVL_READ;
   assign ctrl_wr_s   = wr_s & (AVL_ADDR == 2'd0);
   assign count_wr_s  = wr_s & (AVL_ADDR == 2'd1);
   assign status_wr_s = wr_s & (AVL_ADDR == 2'd3);
   assign data_rd_s   = rd_s & (AVL_ADDR == 2'd2);
   assign abort_s     = ctrl_wr_s & AVL_WRITEDATA[29];
   assign busy_s      = (state_r != S_IDLE);
   assign start_s     = ctrl_wr_s & AVL_WRITEDATA[30] & ~AVL_WRITEDATA[29] & ~busy_s;
   assign sel_nx_s    = start_s ? AVL_WRITEDATA[31] : sel_r;
   assign unused_s    = ^AVL_WRITEDATA[28:17];

   assign fifo_full_s  = (level_r == 4'(FIFO_DEPTH));
   assign fifo_empty_s = (level_r == 4'd0);
   assign in_cap_s     = (state_r == S_CAPTURE);

   // hold_r marks a completed word parked in pack_r while the FIFO is full
   assign cap_word_s  = lane_insert(pack_r, lane_r, ROM_Q);
   assign word_done_s = hold_r | (lane_r == 2'd3) | (remaining_r == 17'd1);
   assign push_word_s = hold_r ? pack_r : cap_word_s;
   assign last_s      = hold_r ? (remaining_r == 17'd0) : (remaining_r == 17'd1);
   assign cap_push_s  = in_cap_s & word_done_s & ~fifo_full_s & ~abort_s;
   assign done_set_s  = cap_push_s & last_s;
   assign pop_s       = data_rd_s & ~fifo_empty_s;
   assign status_s    = {checksum_r, 5'd0, level_r[2:0], 3'd0, done_r, underflow_r,
                         fifo_full_s, fifo_empty_s, busy_s};

   // Next-state logic for the read sequencer
   always_comb begin
      state_nx_s = state_r;
      if (abort_s) begin
         state_nx_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start_s && (count_r != 17'd0)) state_nx_s = S_REQ;
               else                               state_nx_s = S_IDLE;
            end
            S_REQ:  state_nx_s = (ROM_LATENCY > 1) ? S_WAIT : S_CAPTURE;
            S_WAIT: begin
               if (wait_cnt_r == WAIT_LAST) state_nx_s = S_CAPTURE;
               else                         state_nx_s = S_WAIT;
            end
            S_CAPTURE: begin
               if (word_done_s && fifo_full_s) state_nx_s = S_CAPTURE;
               else if (last_s)                state_nx_s = S_IDLE;
               else                            state_nx_s = S_REQ;
            end
            default: state_nx_s = S_IDLE;
         endcase
      end
   end

   // State register, wait counter and registered strobes
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r    <= S_IDLE;
         wait_cnt_r <= 3'd0;
         prg_read_r <= 1'b0;
         chr_read_r <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         wait_cnt_r <= ((state_r == S_WAIT) && (state_nx_s == S_WAIT)) ? wait_cnt_r + 3'd1 : 3'd0;
         prg_read_r <= (state_nx_s == S_REQ) &  sel_nx_s;
         chr_read_r <= (state_nx_s == S_REQ) & ~sel_nx_s;
      end
   end

   // Job setup, byte capture, packing and checksum; the sample is taken once per byte
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         addr_r <= 16'd0; sel_r <= 1'b0; count_r <= 17'd0; remaining_r <= 17'd0;
         checksum_r <= 16'd0; pack_r <= 32'd0; lane_r <= 2'd0; hold_r <= 1'b0;
      end else if (abort_s) begin
         pack_r <= 32'd0; lane_r <= 2'd0; hold_r <= 1'b0;
      end else if (start_s) begin
         addr_r <= AVL_WRITEDATA[15:0]; sel_r <= AVL_WRITEDATA[31]; remaining_r <= count_r;
         checksum_r <= 16'd0; pack_r <= 32'd0; lane_r <= 2'd0; hold_r <= 1'b0;
      end else if (in_cap_s) begin
         if (!hold_r) begin
            checksum_r  <= csum_add(checksum_r, ROM_Q);
            remaining_r <= remaining_r - 17'd1;
            addr_r      <= addr_r + 16'd1;
         end
         if (word_done_s && fifo_full_s) begin
            pack_r <= push_word_s; hold_r <= 1'b1;
         end else if (word_done_s) begin
            pack_r <= 32'd0; lane_r <= 2'd0; hold_r <= 1'b0;
         end else begin
            pack_r <= cap_word_s; lane_r <= lane_r + 2'd1;
         end
      end else if (count_wr_s && !busy_s) begin
         count_r <= AVL_WRITEDATA[16:0];
      end
   end

   // Sticky flags; a set in the same cycle as a clear wins
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         done_r <= 1'b0; underflow_r <= 1'b0;
      end else if (start_s) begin
         done_r <= (count_r == 17'd0); underflow_r <= 1'b0;
      end else begin
         done_r      <= done_set_s | (done_r & ~status_wr_s);
         underflow_r <= (data_rd_s & fifo_empty_s) | (underflow_r & ~status_wr_s);
      end
   end

   // Word FIFO with simultaneous push/pop support
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_r <= {PTR_W{1'b0}}; rd_ptr_r <= {PTR_W{1'b0}}; level_r <= 4'd0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 32'd0;
      end else if (abort_s) begin
         wr_ptr_r <= {PTR_W{1'b0}}; rd_ptr_r <= {PTR_W{1'b0}}; level_r <= 4'd0;
      end else begin
         if (cap_push_s) begin
            mem_r[wr_ptr_r] <= push_word_s;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
         case ({cap_push_s, pop_s})
            2'b10:   level_r <= level_r + 4'd1;
            2'b01:   level_r <= level_r - 4'd1;
            default: level_r <= level_r;
         endcase
      end
   end

   // Registered Avalon read data, fixed latency of one cycle
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         readdata_r <= 32'd0;
      end else if (rd_s) begin
         case (AVL_ADDR)
            2'd0:    readdata_r <= {sel_r, 15'd0, addr_r};
            2'd1:    readdata_r <= {15'd0, remaining_r};
            2'd2:    readdata_r <= fifo_empty_s ? 32'd0 : mem_r[rd_ptr_r];
            default: readdata_r <= status_s;
         endcase
      end else begin
         readdata_r <= 32'd0;
      end
   end

   assign AVL_READDATA = readdata_r;
   assign ROM_ADDR     = addr_r;
   assign PRG_ROM_READ = prg_read_r;
   assign CHR_ROM_READ = chr_read_r;
endmodule

// File: tb/tb_rom_readback.sv
// tb_rom_readback: table-driven readback jobs plus hand-written stall, underflow,
// abort and reset sequences against a ROM model that returns addr[7:0].
`timescale 1ns/1ps
module tb_rom_readback;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  avl_addr = 2'd0;
   logic        avl_cs = 1'b0, avl_read = 1'b0, avl_write = 1'b0;
   logic [31:0] avl_wdata = 32'd0;
   logic [31:0] avl_rdata;
   logic [15:0] rom_addr;
   logic        prg_read, chr_read;
   logic [7:0]  rom_q, q0, q1;

   always #5 clk = ~clk;

   rom_readback #(.ROM_LATENCY(LAT), .FIFO_DEPTH(4)) dut (
      .CLK(clk), .RESET_N(rst_n), .AVL_ADDR(avl_addr), .AVL_CS(avl_cs),
      .AVL_READ(avl_read), .AVL_WRITE(avl_write), .AVL_WRITEDATA(avl_wdata),
      .AVL_READDATA(avl_rdata), .ROM_ADDR(rom_addr), .PRG_ROM_READ(prg_read),
      .CHR_ROM_READ(chr_read), .ROM_Q(rom_q));

   // Two-stage ROM: data appears LAT cycles after the strobe, garbage otherwise
   always @(posedge clk) begin
      q0 <= (prg_read | chr_read) ? rom_addr[7:0] : 8'hEE;
      q1 <= q0;
   end
   assign rom_q = q1;

   int n_prg = 0, n_chr = 0, n_both = 0, cyc = 0;
   logic [15:0] saddr_q[$];
   int          scyc_q[$];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (prg_read) n_prg <= n_prg + 1;
      if (chr_read) n_chr <= n_chr + 1;
      if (prg_read & chr_read) n_both <= n_both + 1;
      if (prg_read | chr_read) begin
         saddr_q.push_back(rom_addr);
         scyc_q.push_back(cyc);
      end
   end

   int n_tests = 0, n_fail = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      avl_addr = a; avl_wdata = d; avl_cs = 1'b1; avl_write = 1'b1;
      @(posedge clk); #1;
      avl_cs = 1'b0; avl_write = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      avl_addr = a; avl_cs = 1'b1; avl_read = 1'b1;
      @(posedge clk); #1;
      avl_cs = 1'b0; avl_read = 1'b0;
      d = avl_rdata;
   endtask

   task automatic wait_idle(input string name);
      logic [31:0] st;
      int k;
      st = 32'd1; k = 0;
      while (st[0] && k < 300) begin
         bus_rd(2'd3, st);
         k++;
      end
      check(name, {31'd0, st[0]}, 32'd0);
   endtask

   typedef struct {
      logic        sel;
      logic [15:0] start;
      logic [16:0] count;
      int          nwords;
      logic [31:0] w0, w1;
      logic [15:0] csum;
      logic [15:0] end_addr;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vec_t vecs[5];
      vec_t v;
      logic [31:0] d;
      int b_prg, b_chr, b_q, n_sel, n_oth;

      vecs[0] = '{1'b1, 16'h8000, 17'd4, 1, 32'h03020100, 32'h00000000, 16'h0006, 16'h8004};
      vecs[1] = '{1'b0, 16'h0010, 17'd6, 2, 32'h13121110, 32'h00001514, 16'h006F, 16'h0016};
      vecs[2] = '{1'b1, 16'hFFFE, 17'd4, 1, 32'h0100FFFE, 32'h00000000, 16'h01FE, 16'h0002};
      vecs[3] = '{1'b0, 16'h1234, 17'd1, 1, 32'h00000034, 32'h00000000, 16'h0034, 16'h1235};
      vecs[4] = '{1'b1, 16'h0500, 17'd0, 0, 32'h00000000, 32'h00000000, 16'h0000, 16'h0500};

      repeat (3) @(posedge clk);
      #1;
      check("rst_readdata", avl_rdata, 32'd0);
      check("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
      check("rst_strobes", {30'd0, prg_read, chr_read}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      bus_rd(2'd3, d); check("rst_status", d, 32'h00000002);
      bus_rd(2'd1, d); check("rst_count", d, 32'd0);

      for (int vi = 0; vi < 5; vi++) begin
         v = vecs[vi];
         bus_wr(2'd3, 32'd0);
         bus_wr(2'd1, {15'd0, v.count});
         b_prg = n_prg; b_chr = n_chr; b_q = saddr_q.size();
         bus_wr(2'd0, {v.sel, 1'b1, 1'b0, 13'd0, v.start});
         if (v.count != 17'd0)
            check("vec_req_next_cycle", {30'd0, prg_read, chr_read}, {30'd0, v.sel, ~v.sel});
         wait_idle("vec_idle");
         bus_rd(2'd3, d);
         check("vec_status", d, {v.csum, 5'd0, 3'(v.nwords), 3'd0, 1'b1, 1'b0, 1'b0,
                                 (v.nwords == 0), 1'b0});
         bus_rd(2'd0, d); check("vec_ctrl", d, {v.sel, 15'd0, v.end_addr});
         bus_rd(2'd1, d); check("vec_remaining", d, 32'd0);
         if (v.nwords > 0) begin bus_rd(2'd2, d); check("vec_word0", d, v.w0); end
         if (v.nwords > 1) begin bus_rd(2'd2, d); check("vec_word1", d, v.w1); end
         bus_rd(2'd3, d); check("vec_drained", d & 32'h0000071F, 32'h00000012);
         n_sel = v.sel ? (n_prg - b_prg) : (n_chr - b_chr);
         n_oth = v.sel ? (n_chr - b_chr) : (n_prg - b_prg);
         check("vec_sel_strobes", 32'(n_sel), 32'(v.count));
         check("vec_other_strobes", 32'(n_oth), 32'd0);
         for (int i = 0; i < int'(v.count); i++)
            check("vec_strobe_addr", {16'd0, saddr_q[b_q + i]}, {16'd0, v.start + 16'(i)});
         if (v.count >= 17'd2)
            check("vec_strobe_gap", 32'(scyc_q[b_q + 1] - scyc_q[b_q]), 32'(LAT + 1));
      end

      // Stall: 20 bytes, nothing drained until the FIFO has filled
      bus_wr(2'd3, 32'd0);
      bus_wr(2'd1, 32'd20);
      b_prg = n_prg; b_chr = n_chr; b_q = saddr_q.size();
      bus_wr(2'd0, {1'b1, 1'b1, 1'b0, 13'd0, 16'h0000});
      repeat (100) @(posedge clk);
      #1;
      bus_rd(2'd3, d); check("stall_status", d & 32'h0000071F, 32'h00000405);
      bus_wr(2'd1, 32'd5);
      bus_wr(2'd0, {1'b0, 1'b1, 1'b0, 13'd0, 16'h4000});
      for (int i = 0; i < 5; i++) begin
         bus_rd(2'd2, d);
         check("stall_word", d, {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
      end
      wait_idle("stall_idle");
      bus_rd(2'd3, d); check("stall_final_status", d, 32'h00BE0012);
      bus_rd(2'd0, d); check("stall_ctrl", d, 32'h80000014);
      bus_rd(2'd1, d); check("stall_remaining", d, 32'd0);
      check("stall_prg_strobes", 32'(n_prg - b_prg), 32'd20);
      check("stall_chr_strobes", 32'(n_chr - b_chr), 32'd0);
      for (int i = 0; i < 20; i++)
         check("stall_strobe_addr", {16'd0, saddr_q[b_q + i]}, 32'(i));

      // Underflow on an empty DATA read, cleared by a STATUS write
      bus_rd(2'd2, d); check("uf_data", d, 32'd0);
      bus_rd(2'd3, d); check("uf_flag", {31'd0, d[3]}, 32'd1);
      bus_wr(2'd3, 32'd0);
      bus_rd(2'd3, d); check("uf_cleared", d & 32'h00000018, 32'd0);

      // Abort after five strobes of a 16-byte job
      bus_wr(2'd1, 32'd16);
      b_prg = n_prg;
      bus_wr(2'd0, {1'b1, 1'b1, 1'b0, 13'd0, 16'h0100});
      for (int k = 0; k < 200 && (n_prg - b_prg) < 5; k++) begin
         @(posedge clk); #1;
      end
      bus_wr(2'd0, 32'h20000000);
      repeat (20) @(posedge clk);
      #1;
      check("abort_strobes", 32'(n_prg - b_prg), 32'd5);
      bus_rd(2'd3, d); check("abort_status", d, 32'h00060002);
      bus_rd(2'd1, d); check("abort_remaining", d, 32'd12);

      // Asynchronous reset in the middle of a job
      bus_wr(2'd1, 32'd16);
      bus_wr(2'd0, {1'b1, 1'b1, 1'b0, 13'd0, 16'h2000});
      repeat (7) @(posedge clk);
      bus_rd(2'd0, d);
      #1; rst_n = 1'b0;
      #1;
      check("arst_readdata", avl_rdata, 32'd0);
      check("arst_rom_addr", {16'd0, rom_addr}, 32'd0);
      check("arst_strobes", {30'd0, prg_read, chr_read}, 32'd0);
      b_prg = n_prg;
      repeat (3) @(posedge clk);
      #1;
      check("arst_no_strobe", 32'(n_prg - b_prg), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("arst_idle_strobes", 32'(n_prg - b_prg), 32'd0);
      bus_rd(2'd3, d); check("arst_status", d, 32'h00000002);
      bus_rd(2'd0, d); check("arst_ctrl", d, 32'd0);
      bus_rd(2'd1, d); check("arst_count", d, 32'd0);

      check("both_strobes", 32'(n_both), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
